// File: rtl/isqrt_reconstruct_if.sv
`default_nettype none
// ============================================================================
//  Module   : isqrt_reconstruct_if
//  Purpose  : start/busy/done handshake and data bus for the square-root
//             reconstruction block (root and remainder in, radicand out).
//  Revision : 1.0 - initial release
// ============================================================================
interface isqrt_reconstruct_if #(
    parameter int RW = 4
) ();
    logic              start;
    logic [RW-1:0]     root_in;
    logic [RW:0]       rem_in;
    logic              busy;
    logic              done;
    logic [2*RW-1:0]   square_out;
    logic              err;

    // Requester side: issues operations and observes results.
    modport master (
        output start, root_in, rem_in,
        input  busy, done, square_out, err
    );

    // Engine side.
    modport slave (
        input  start, root_in, rem_in,
        output busy, done, square_out, err
    );
endinterface
`default_nettype wire

// File: rtl/isqrt_reconstruct.sv
`default_nettype none
// ============================================================================
//  Module   : isqrt_reconstruct
//  Purpose  : Rebuilds N = R*R + REM from an integer square root R and its
//             remainder REM using a shift-and-add multiplier that retires one
//             root bit per clock. Flags remainders that exceed 2*R.
//  Revision : 1.0 - initial release
// ============================================================================
module isqrt_reconstruct #(
    parameter int RW = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    isqrt_reconstruct_if.slave    bus
);
    localparam int c_W  = 2 * RW;
    localparam int c_CW = (RW > 1) ? $clog2(RW) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(RW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_W-1:0]    r_acc;
    logic [c_W-1:0]    r_mcand;
    logic [RW-1:0]     r_mplr;
    logic [c_CW-1:0]   r_cnt;
    logic              r_err_pend;
    logic [c_W-1:0]    r_square;
    logic              r_err;
    logic [c_W-1:0]    w_acc_next;
    logic              w_last;

    // Partial product for the current multiplier bit; wraps at 2*RW bits.
    assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last     = (r_cnt == c_CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = bus.start ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, shift-and-add iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplr     <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_square   <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc      <= c_W'(bus.rem_in);
                        r_mcand    <= c_W'(bus.root_in);
                        r_mplr     <= bus.root_in;
                        r_cnt      <= '0;
                        r_err_pend <= (bus.rem_in > {bus.root_in, 1'b0});
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    // Result publishes on the same edge as the final add.
                    if (w_last) begin
                        r_square <= w_acc_next;
                        r_err    <= r_err_pend;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.square_out = r_square;
    assign bus.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_isqrt_reconstruct.sv
`default_nettype none
// ============================================================================
//  Module   : tb_isqrt_reconstruct
//  Purpose  : Directed self-checking bench for isqrt_reconstruct (RW=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_isqrt_reconstruct;
    localparam int c_RW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    isqrt_reconstruct_if #(.RW(c_RW)) bus ();

    isqrt_reconstruct #(.RW(c_RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One operation: start sampled at the next edge, then wait (bounded) for done.
    // Returns the number of edges after the capture edge at which done was seen
    // (0 if it never arrived within the budget).
    task automatic do_op(input logic [3:0] r, input logic [4:0] m,
                         output logic [7:0] sq, output logic e, output int lat);
        lat = 0;
        @(negedge clk);
        bus.root_in = r;
        bus.rem_in  = m;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        sq = bus.square_out;
        e  = bus.err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.root_in = '0;
        bus.rem_in  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.square_out !== 8'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sq=%0d err=%b, required 0 0 0 0",
                     bus.busy, bus.done, bus.square_out, bus.err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b, required 0", bus.busy);
        end
    endtask

    // Cycle-accurate latency for R=11, REM=7.
    task automatic test_latency();
        logic [7:0] exp_done;
        exp_done = 8'b0001_0000;   // done only after edge 4
        @(negedge clk);
        bus.root_in = 4'd11;
        bus.rem_in  = 5'd7;
        bus.start   = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);          // now after edge k
            bus.start = 1'b0;
            checks++;
            if (bus.done !== exp_done[k]) begin
                errors++;
                $display("FAIL latency_done edge%0d: done=%b, required %b", k, bus.done, exp_done[k]);
            end
            checks++;
            if (bus.busy !== (k <= 4)) begin
                errors++;
                $display("FAIL latency_busy edge%0d: busy=%b, required %b", k, bus.busy, (k <= 4));
            end
            if (k == 2) begin
                checks++;
                if (bus.square_out !== 8'd0) begin
                    errors++;
                    $display("FAIL hold_during_run: sq=%0d, required 0", bus.square_out);
                end
            end
            if (k == 4) begin
                checks++;
                if (bus.square_out !== 8'd128 || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_11_7: sq=%0d err=%b, required 128 0", bus.square_out, bus.err);
                end
            end
        end
        checks++;
        if (bus.square_out !== 8'd128) begin
            errors++;
            $display("FAIL hold_in_idle: sq=%0d, required 128", bus.square_out);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] r_tab [4] = '{4'd0, 4'd15, 4'd15, 4'd3};
        logic [4:0] m_tab [4] = '{5'd0, 5'd30, 5'd31, 5'd7};
        logic [7:0] q_tab [4] = '{8'd0, 8'd255, 8'd0, 8'd16};
        logic       e_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] sq;
        logic       e;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            do_op(r_tab[i], m_tab[i], sq, e, lat);
            checks++;
            if (lat != 4 || sq !== q_tab[i] || e !== e_tab[i]) begin
                errors++;
                $display("FAIL vector R=%0d REM=%0d: sq=%0d err=%b lat=%0d, required %0d %b 4",
                         r_tab[i], m_tab[i], sq, e, lat, q_tab[i], e_tab[i]);
            end
        end
    endtask

    // start held high: done every 6 cycles; root change mid-RUN only affects the next op.
    task automatic test_back_to_back();
        @(negedge clk);
        bus.root_in = 4'd5;
        bus.rem_in  = 5'd2;
        bus.start   = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k == 7) bus.root_in = 4'd9;
            checks++;
            if (bus.done !== (k == 4 || k == 10 || k == 16)) begin
                errors++;
                $display("FAIL b2b_done edge%0d: done=%b, required %b", k, bus.done,
                         (k == 4 || k == 10 || k == 16));
            end
            if (k == 4 || k == 10) begin
                checks++;
                if (bus.square_out !== 8'd27) begin
                    errors++;
                    $display("FAIL b2b_result edge%0d: sq=%0d, required 27", k, bus.square_out);
                end
            end
            if (k == 16) begin
                checks++;
                if (bus.square_out !== 8'd83) begin
                    errors++;
                    $display("FAIL b2b_new_root: sq=%0d, required 83", bus.square_out);
                end
            end
        end
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.root_in = 4'd12;
        bus.rem_in  = 5'd4;
        bus.start   = 1'b1;
        @(negedge clk);              // after edge 0
        bus.start = 1'b0;
        @(negedge clk);              // after edge 1
        @(negedge clk);              // after edge 2
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.square_out !== 8'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b sq=%0d err=%b, required 0 0 0 0",
                     bus.busy, bus.done, bus.square_out, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_async k=%0d: busy=%b done=%b, required 0 0", k, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [7:0] sq;
        logic       e;
        int         lat;
        int         r;
        for (int n = 0; n < 256; n++) begin
            r = 0;
            while ((r + 1) * (r + 1) <= n) r++;
            do_op(4'(r), 5'(n - r * r), sq, e, lat);
            checks++;
            if (lat != 4 || sq !== 8'(n) || e !== 1'b0) begin
                errors++;
                $display("FAIL roundtrip N=%0d: sq=%0d err=%b lat=%0d, required %0d 0 4", n, sq, e, lat, n);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_async_reset();
        test_roundtrip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/isqrt_reconstruct.md
Name: isqrt_reconstruct

Overview:
- Inverse of the integer square-root engine. Takes a root R and remainder REM and rebuilds the radicand N = R*R + REM with a sequential shift-and-add multiplier, one root bit per clock.
- Used as the self-check path: sqrt output → this block → compare against the original ui_in. Also usable standalone as a small squarer.
- Internal submodule behind the tile top level; a start/busy/done handshake lets it share the tile's 8-bit I/O.

Parameters:
- RW, 4, root width in bits.
- Derived, not overridable: remainder width RW+1 and result width 2*RW.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- root_in  input  RW  root R.
- rem_in  input  RW+1  remainder REM.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- square_out  output  2*RW  (R*R + REM) mod 2^(2*RW), registered.
- err  output  1  high when REM > 2*R, i.e. not a legal sqrt remainder; registered with square_out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc, multiplicand, multiplier and counter=0; square_out=0; err=0; done=0; busy=0. Release is synchronous to the next clk edge as normal.
- States: IDLE(00), RUN(01), DONE(10). Encoding 11 is unreachable; if entered, return to IDLE on the next edge.
- IDLE:
  - If start=1 at an edge: acc ← zero-extended rem_in; mcand ← zero-extended root_in (2*RW bits); mplr ← root_in; cnt ← 0; err_pend ← (rem_in > {root_in,1'b0}); go to RUN.
  - Otherwise hold.
- RUN, one edge per root bit:
  - If mplr[0]=1, acc ← acc + mcand, truncated to 2*RW bits.
  - mcand ← mcand << 1; mplr ← mplr >> 1; cnt ← cnt + 1.
  - When cnt == RW-1: go to DONE, and load square_out and err from the final acc and err_pend on that same edge.
- DONE: done=1 for exactly this one cycle; next edge → IDLE unconditionally.
- Latency: start sampled at edge 0; RUN occupies edges 1..RW; done is high between edge RW and edge RW+1. For RW=4, done is high between edges 4 and 5. Throughput is one operation per RW+2 cycles.
- square_out and err hold their values until the next DONE entry. They do not change during IDLE or RUN.
- start while busy (RUN or DONE) is ignored and not queued. Input changes after the capture edge have no effect.
- Arithmetic: for a legal REM ≤ 2R, the result is ≤ (R+1)^2 − 1, so it fits in 2*RW bits. An illegal REM wraps modulo 2^(2*RW) and sets err.
- Reset asserted mid-RUN or in DONE: immediate return to reset values, no done pulse, and square_out clears to 0.
- Counter width is clog2(RW). It must not wrap before the DONE transition.

Test Plan:
- RW=4, root_in=11, rem_in=7, start pulse at edge 0 → busy=1 from edge 0; done high between edges 4 and 5; square_out=128, err=0.
- root_in=0, rem_in=0 → square_out=0, err=0. Then root_in=15, rem_in=30 → square_out=255, err=0.
- Illegal remainder: root_in=15, rem_in=31 → square_out=0 (wrap), err=1. root_in=3, rem_in=7 → square_out=16, err=1.
- Hold start=1 continuously with root_in=5, rem_in=2:
  - Result 27 pulses done once per 6 cycles.
  - Changing root_in to 9 mid-RUN does not affect the current result; the next operation returns 83.
- Deassert rst_n asynchronously between edges 2 and 3 of a RUN (root_in=12, rem_in=4) → busy, done and square_out go to 0 immediately with no clock. After release, the block idles until the next start.
- Round-trip: for every N in 0..255, feed the sqrt engine's root and remainder → square_out=N and err=0 in all 256 cases.
